// File: rtl/scan_dff_bank_rs.sv
// Mux-scan register bank with asynchronous reset and synchronous preset.
// It has a parallel load, a serial shift chain SI -> Q[0] -> ... -> Q[WIDTH-1] -> SO,
// and a shift counter that raises SCAN_DONE for one cycle after each full chain pass.
module scan_dff_bank_rs #(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1,
    parameter int unsigned      CW      = $clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             SETN,
    input  logic             SE,
    input  logic             SI,
    input  logic             EN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             SO,
    output logic [CW-1:0]    SHIFT_CNT,
    output logic             SCAN_DONE
);

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_d, q_q;
    logic [CW-1:0]    cnt_d, cnt_q;
    logic             done_d, done_q;
    logic             cnt_wrap;
    logic             shift_act;
    logic [WIDTH-1:0] q_shift;

    // Next state; the ternary form lets X on the control inputs reach Q in simulation.
    always_comb begin
        q_d       = q_q;
        cnt_d     = '0;
        done_d    = 1'b0;
        q_shift   = {q_q[WIDTH-2:0], SI};
        cnt_wrap  = (cnt_q == CNT_LAST);
        shift_act = SETN & SE;

        q_d    = !SETN ? SET_VAL :
                 SE    ? q_shift :
                 EN    ? D       : q_q;
        cnt_d  = shift_act ? (cnt_wrap ? '0 : cnt_q + CW'(1)) : '0;
        done_d = shift_act & cnt_wrap;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            q_q    <= RST_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    // Drive the outputs; SO is taken straight from the last flop with no extra stage.
    always_comb begin
        Q         = q_q;
        SO        = q_q[WIDTH-1];
        SHIFT_CNT = cnt_q;
        SCAN_DONE = done_q;
    end

endmodule

// File: tb/tb_scan_dff_bank_rs.sv
// Directed self-checking bench for scan_dff_bank_rs (WIDTH=8).
module tb_scan_dff_bank_rs;

    logic       CLK;
    logic       RN;
    logic       SETN;
    logic       SE;
    logic       SI;
    logic       EN;
    logic [7:0] D;
    logic [7:0] Q;
    logic       SO;
    logic [2:0] SHIFT_CNT;
    logic       SCAN_DONE;
    logic       clk_run;

    int n_checks;
    int n_fail;

    scan_dff_bank_rs #(.WIDTH(8)) dut (
        .CLK(CLK), .RN(RN), .SETN(SETN), .SE(SE), .SI(SI), .EN(EN), .D(D),
        .Q(Q), .SO(SO), .SHIFT_CNT(SHIFT_CNT), .SCAN_DONE(SCAN_DONE)
    );

    always begin
        #5;
        if (clk_run) CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eq, input logic [2:0] ec,
                           input logic ed);
        chk({tag, ".Q"}, 32'(Q), 32'(eq));
        chk({tag, ".CNT"}, 32'(SHIFT_CNT), 32'(ec));
        chk({tag, ".DONE"}, 32'(SCAN_DONE), 32'(ed));
    endtask

    logic [7:0] t3_bits;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        CLK      = 1'b0;
        clk_run  = 1'b0;
        RN       = 1'b1;
        SETN     = 1'b1;
        SE       = 1'b0;
        SI       = 1'b0;
        EN       = 1'b0;
        D        = 8'h00;

        // T1: asynchronous reset with the clock idle
        #1 RN = 1'b0;
        #2;
        chk_all("t1_reset", 8'h00, 3'd0, 1'b0);
        chk("t1_so", 32'(SO), 32'd0);
        RN      = 1'b1;
        clk_run = 1'b1;

        // T2: parallel load, then hold while D changes
        EN = 1'b1; D = 8'hA5;
        step();
        chk_all("t2_load", 8'hA5, 3'd0, 1'b0);
        EN = 1'b0; D = 8'h3C;
        step();
        chk_all("t2_hold1", 8'hA5, 3'd0, 1'b0);
        step();
        chk_all("t2_hold2", 8'hA5, 3'd0, 1'b0);

        // T3: one full shift pass from Q=00, SI sequence 1,0,1,1,0,0,1,0
        EN = 1'b1; D = 8'h00;
        step();
        chk("t3_clear", 32'(Q), 32'h00);
        EN = 1'b0; SE = 1'b1; D = 8'hFF;
        t3_bits = 8'b1011_0010;
        for (int i = 0; i < 8; i++) begin
            SI = t3_bits[7 - i];
            step();
            chk("t3_cnt", 32'(SHIFT_CNT), 32'((i + 1) % 8));
            chk("t3_done", 32'(SCAN_DONE), 32'(i == 7));
        end
        chk("t3_q", 32'(Q), 32'hB2);
        chk("t3_so", 32'(SO), 32'd1);

        // Functional cycle between passes: pulse drops, counter stays clear
        SE = 1'b0;
        step();
        chk_all("t3_after", 8'hB2, 3'd0, 1'b0);

        // T4: 16 continuous shifts, pulse after edges 8 and 16 only
        SE = 1'b1;
        for (int i = 0; i < 16; i++) begin
            SI = 1'(i & 1);
            step();
            chk("t4_done", 32'(SCAN_DONE), 32'(i == 7 || i == 15));
            chk("t4_cnt", 32'(SHIFT_CNT), 32'((i + 1) % 8));
        end
        chk("t4_q", 32'(Q), 32'h55);
        SE = 1'b0;
        step();

        // T5: preset on shift edge 5 wins over shift and load, pass restarts
        SE = 1'b1; SI = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("t5_cnt4", 32'(SHIFT_CNT), 32'd4);
        SETN = 1'b0; EN = 1'b1; D = 8'h00;
        step();
        chk_all("t5_preset", 8'hFF, 3'd0, 1'b0);
        SETN = 1'b1; EN = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t5_done", 32'(SCAN_DONE), 32'(i == 7));
        end
        chk("t5_q", 32'(Q), 32'h00);
        SE = 1'b0;
        step();

        // T6: asynchronous reset between shift edges 3 and 4
        SE = 1'b1; SI = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk_all("t6_pre", 8'h07, 3'd3, 1'b0);
        #1 RN = 1'b0;
        #1;
        chk_all("t6_rst", 8'h00, 3'd0, 1'b0);
        RN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t6_done", 32'(SCAN_DONE), 32'(i == 7));
        end
        chk("t6_q", 32'(Q), 32'hFF);
        chk("t6_so", 32'(SO), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
